// File: rtl/nios2_ocimem_pkg.sv
// Shared types and constants for the OCI memory arbiter.
package nios2_ocimem_pkg;

    localparam int unsigned OCI_ADDR_W = 8;
    localparam int unsigned OCI_DATA_W = 32;

    // jdo field positions (fixed for a 32-bit RAM word)
    localparam int unsigned JDO_ADDR_LSB  = 18;
    localparam int unsigned JDO_RDFLAG    = 17;
    localparam int unsigned JDO_WDATA_MSB = 34;
    localparam int unsigned JDO_WDATA_LSB = 3;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_READ,
        OP_WRITE
    } jtag_op_t;

    typedef enum logic {
        REQ_CPU,
        REQ_JTAG
    } requester_t;

    // One-hot grant bit positions
    localparam int unsigned GNT_CPU  = 0;
    localparam int unsigned GNT_JTAG = 1;

endpackage

// File: rtl/nios2_ocimem_rr_arb2.sv
// Two-requester round-robin arbiter. grant is one-hot: bit 0 CPU, bit 1 JTAG.
import nios2_ocimem_pkg::*;

module nios2_ocimem_rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_cpu,
    input  logic       req_jtag,
    output logic [1:0] grant
);

    requester_t last_grant;

    // On contention the requester that did not win last time is granted
    always_comb begin
        grant = 2'b00;
        if (req_cpu && req_jtag) begin
            grant = (last_grant == REQ_CPU) ? 2'b10 : 2'b01;
        end else if (req_jtag) begin
            grant = 2'b10;
        end else if (req_cpu) begin
            grant = 2'b01;
        end
    end

    // Remember the most recent winner
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant <= REQ_CPU;
        end else if (grant[GNT_JTAG]) begin
            last_grant <= REQ_JTAG;
        end else if (grant[GNT_CPU]) begin
            last_grant <= REQ_CPU;
        end
    end

endmodule

// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG debug path and the
// CPU debug-slave port; routes read data back to MonDReg or the CPU.
import nios2_ocimem_pkg::*;

module nios2_ocimem_arbiter #(
    parameter int unsigned ADDR_W = OCI_ADDR_W,
    parameter int unsigned DATA_W = OCI_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_waitrequest,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [31:0]       MonDReg,
    output logic              jtag_rd_done,
    output logic              jtag_overrun
);

    jtag_op_t          slot_op;
    logic [DATA_W-1:0] slot_wdata;
    logic [ADDR_W-1:0] jtag_addr;
    logic              overrun_q;
    logic              rd_valid_q;
    requester_t        rd_tag_q;
    logic [31:0]       mon_q;
    logic              done_q;
    logic [1:0]        grant;
    logic              grant_cpu;
    logic              grant_jtag;
    logic              slot_full;
    logic              unused_jdo;

    assign slot_full  = (slot_op != OP_NONE);
    assign unused_jdo = ^{jdo[37:35], jdo[2:0]};

    nios2_ocimem_rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_cpu  (cpu_read | cpu_write),
        .req_jtag (slot_full),
        .grant    (grant)
    );

    assign grant_cpu  = grant[GNT_CPU];
    assign grant_jtag = grant[GNT_JTAG];

    // Drive the RAM port from whichever requester holds the grant
    always_comb begin
        ram_en    = grant_cpu | grant_jtag;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (grant_cpu) begin
            ram_we    = cpu_write;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (grant_jtag) begin
            ram_we    = (slot_op == OP_WRITE);
            ram_addr  = jtag_addr;
            ram_wdata = slot_wdata;
        end
    end

    assign cpu_waitrequest = ~grant_cpu;
    assign cpu_rvalid      = rd_valid_q && (rd_tag_q == REQ_CPU);
    assign cpu_rdata       = cpu_rvalid ? ram_rdata : '0;
    assign MonDReg         = mon_q;
    assign jtag_rd_done    = done_q;
    assign jtag_overrun    = overrun_q;

    // JTAG slot, address counter and sticky overrun; a load beats the increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_op    <= OP_NONE;
            slot_wdata <= '0;
            jtag_addr  <= '0;
            overrun_q  <= 1'b0;
        end else begin
            if (grant_jtag) begin
                slot_op   <= OP_NONE;
                jtag_addr <= jtag_addr + 1'b1;
            end
            if (take_action_ocimem_a) begin
                jtag_addr <= jdo[JDO_ADDR_LSB +: ADDR_W];
                if (jdo[JDO_RDFLAG]) begin
                    if (slot_full) overrun_q <= 1'b1;
                    else           slot_op   <= OP_READ;
                end
                if (take_action_ocimem_b || take_no_action_ocimem_a) overrun_q <= 1'b1;
            end else if (take_action_ocimem_b) begin
                if (slot_full) begin
                    overrun_q <= 1'b1;
                end else begin
                    slot_op    <= OP_WRITE;
                    slot_wdata <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
                end
                if (take_no_action_ocimem_a) overrun_q <= 1'b1;
            end else if (take_no_action_ocimem_a) begin
                if (slot_full) overrun_q <= 1'b1;
                else           slot_op   <= OP_READ;
            end
        end
    end

    // Return-tag pipeline: steer read data one cycle after the grant
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_tag_q   <= REQ_CPU;
            mon_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            rd_valid_q <= ram_en && !ram_we;
            rd_tag_q   <= grant_jtag ? REQ_JTAG : REQ_CPU;
            done_q     <= rd_valid_q && (rd_tag_q == REQ_JTAG);
            if (rd_valid_q && (rd_tag_q == REQ_JTAG)) begin
                mon_q <= ram_rdata[31:0];
            end
        end
    end

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Randomized scoreboard bench for nios2_ocimem_arbiter with a RAM model.
module tb_nios2_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [7:0]  cpu_addr;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_wdata;
    logic        cpu_waitrequest;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic [31:0] MonDReg;
    logic        jtag_rd_done, jtag_overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_cpu_q[$];
    logic [31:0] exp_jtag_q[$];

    always #5 clk = ~clk;

    nios2_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .cpu_addr                (cpu_addr),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_wdata               (cpu_wdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .cpu_rdata               (cpu_rdata),
        .cpu_rvalid              (cpu_rvalid),
        .ram_en                  (ram_en),
        .ram_we                  (ram_we),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .jtag_rd_done            (jtag_rd_done),
        .jtag_overrun            (jtag_overrun)
    );

    function automatic logic [31:0] init_word(int i);
        return (i == 16) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, 8'(i)};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-port RAM with 1-cycle read latency
    logic [31:0] ram [256];
    logic        ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        ram_rdata     <= ram[ram_addr];
        end
    end

    // Reference model: transaction rules evaluated once per cycle
    initial begin : model
        logic [31:0] shadow [256];
        int          slot;       // 0 empty, 1 read, 2 write
        logic [31:0] swd;
        logic [7:0]  ja;
        logic        last_j, ov, gj, gc, full, ewe;
        logic [7:0]  ea;
        logic [31:0] ed;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        slot = 0; swd = '0; ja = '0; last_j = 1'b0; ov = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                slot = 0; ja = '0; last_j = 1'b0; ov = 1'b0;
                exp_cpu_q.delete();
                exp_jtag_q.delete();
                check("rst_waitrequest", 32'(cpu_waitrequest), 32'd1);
                check("rst_ram_en", 32'(ram_en), 32'd0);
                check("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
                check("rst_rd_done", 32'(jtag_rd_done), 32'd0);
                check("rst_mondreg", MonDReg, 32'd0);
                check("rst_overrun", 32'(jtag_overrun), 32'd0);
                continue;
            end
            full = (slot != 0);
            gj   = full && (!(cpu_read | cpu_write) || !last_j);
            gc   = (cpu_read | cpu_write) && !gj;
            check("overrun", 32'(jtag_overrun), 32'(ov));
            check("ram_en", 32'(ram_en), 32'(gj | gc));
            check("waitrequest", 32'(cpu_waitrequest), 32'(!gc));
            if (gc || gj) begin
                if (gc) begin
                    ewe = cpu_write; ea = cpu_addr; ed = cpu_wdata;
                end else begin
                    ewe = (slot == 2); ea = ja; ed = swd;
                end
                check("ram_we", 32'(ram_we), 32'(ewe));
                check("ram_addr", 32'(ram_addr), 32'(ea));
                if (ewe) begin
                    check("ram_wdata", ram_wdata, ed);
                    shadow[ea] = ed;
                end else if (gc) begin
                    exp_cpu_q.push_back(shadow[ea]);
                end else begin
                    exp_jtag_q.push_back(shadow[ea]);
                end
                last_j = gj;
            end
            if (gj) begin
                slot = 0;
                ja   = ja + 8'd1;
            end
            if (take_action_ocimem_a) begin
                ja = jdo[25:18];
                if (jdo[17]) begin
                    if (full) ov = 1'b1;
                    else      slot = 1;
                end
                if (take_action_ocimem_b || take_no_action_ocimem_a) ov = 1'b1;
            end else if (take_action_ocimem_b) begin
                if (full) ov = 1'b1;
                else begin
                    slot = 2;
                    swd  = jdo[34:3];
                end
                if (take_no_action_ocimem_a) ov = 1'b1;
            end else if (take_no_action_ocimem_a) begin
                if (full) ov = 1'b1;
                else      slot = 1;
            end
        end
    end

    // Monitor: pop and compare whenever the DUT presents read data
    always @(negedge clk) begin
        if (reset_n) begin
            if (cpu_rvalid) begin
                if (exp_cpu_q.size() == 0) check("cpu_rvalid_unexpected", 32'd1, 32'd0);
                else check("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
            end
            if (jtag_rd_done) begin
                if (exp_jtag_q.size() == 0) check("rd_done_unexpected", 32'd1, 32'd0);
                else check("mondreg", MonDReg, exp_jtag_q.pop_front());
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        logic acc;
        @(negedge clk);
        acc = !cpu_waitrequest;
        @(posedge clk);
        #1;
        take_action_ocimem_a    = 1'b0;
        take_action_ocimem_b    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        if (acc) begin
            cpu_read  = 1'b0;
            cpu_write = 1'b0;
        end
    endtask

    task automatic do_reset();
        cpu_read = 1'b0; cpu_write = 1'b0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic strobe_a(logic [7:0] addr, logic rd);
        jdo = '0;
        jdo[25:18] = addr;
        jdo[17] = rd;
        take_action_ocimem_a = 1'b1;
        tick();
    endtask

    task automatic strobe_b(logic [31:0] data);
        jdo = '0;
        jdo[34:3] = data;
        take_action_ocimem_b = 1'b1;
        tick();
    endtask

    task automatic strobe_na();
        take_no_action_ocimem_a = 1'b1;
        tick();
    endtask

    task automatic cpu_req(logic rd, logic wr, logic [7:0] addr, logic [31:0] data);
        cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = data;
    endtask

    initial begin : stim
        int r;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        tick();
        do_reset();

        // JTAG read of 0x10
        strobe_a(8'h10, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        check("mondreg_deadbeef", MonDReg, 32'hDEADBEEF);
        @(posedge clk); #1;

        // Address wrap after a write to 0xFF, then read back 0x00 and 0xFF
        strobe_a(8'hFF, 1'b0);
        strobe_b(32'h12345678);
        repeat (2) tick();
        strobe_na();
        repeat (4) tick();
        strobe_a(8'hFF, 1'b1);
        repeat (4) tick();
        @(negedge clk);
        check("mondreg_wr_ff", MonDReg, 32'h12345678);
        @(posedge clk); #1;

        // Continuous CPU reads racing a JTAG read
        do_reset();
        strobe_a(8'h20, 1'b1);
        cpu_req(1'b1, 1'b0, 8'h05, '0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!cpu_read) cpu_req(1'b1, 1'b0, 8'(6 + i), '0);
        end

        // Two no_action strobes back to back while the CPU holds the RAM
        strobe_na();
        if (!cpu_read) cpu_req(1'b1, 1'b0, 8'h30, '0);
        strobe_na();
        for (int i = 0; i < 6; i++) begin
            if (!cpu_read) cpu_req(1'b1, 1'b0, 8'(8'h31 + i), '0);
            tick();
        end
        repeat (3) tick();
        @(negedge clk);
        check("overrun_sticky", 32'(jtag_overrun), 32'd1);
        @(posedge clk); #1;

        // CPU write then read-back of 0x03
        cpu_req(1'b0, 1'b1, 8'h03, 32'hA5A5A5A5);
        for (int i = 0; i < 10 && (cpu_read || cpu_write); i++) tick();
        cpu_req(1'b1, 1'b0, 8'h03, '0);
        for (int i = 0; i < 10 && (cpu_read || cpu_write); i++) tick();
        repeat (3) tick();

        // Reset right after a JTAG read grant
        do_reset();
        strobe_na();
        tick();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            int k;
            if (c == 1000) do_reset();
            if (!cpu_read && !cpu_write && ($urandom_range(0, 1) == 1)) begin
                k = $urandom_range(1, 3);
                cpu_req(k[0], k[1], 8'($urandom_range(0, 31)), $urandom);
            end
            jdo = 38'({$urandom, $urandom});
            jdo[25:18] = 8'($urandom_range(0, 31));
            r = $urandom_range(0, 15);
            case (r)
                0: take_action_ocimem_a = 1'b1;
                1: take_action_ocimem_b = 1'b1;
                2: take_no_action_ocimem_a = 1'b1;
                3: begin
                    take_action_ocimem_a    = 1'($urandom_range(0, 1));
                    take_action_ocimem_b    = 1'($urandom_range(0, 1));
                    take_no_action_ocimem_a = 1'($urandom_range(0, 1));
                end
                default: ;
            endcase
            tick();
        end

        // Drain outstanding requests
        for (int i = 0; i < 20 && (cpu_read || cpu_write); i++) tick();
        repeat (5) tick();
        check("cpu_q_drained", 32'(exp_cpu_q.size()), 32'd0);
        check("jtag_q_drained", 32'(exp_jtag_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nios2_ocimem_arbiter.md
Name: nios2_ocimem_arbiter

Overview:
- Shares the single-port on-chip debug RAM (OCI memory) between two requesters: the JTAG debug path and the CPU debug-slave port.
- JTAG side: sysclk-domain take_action/no_action strobes plus jdo. The block holds a one-deep JTAG request slot and an auto-incrementing JTAG address counter.
- Arbitration between JTAG and CPU is two-way round-robin. Read data returns to MonDReg for JTAG, or to the CPU read-data port.

Parameters:
- ADDR_W, 8, OCI RAM word-address width.
- DATA_W, 32, RAM word width. jdo field positions are fixed for 32.

Ports:
- clk in 1: system clock.
- reset_n in 1: asynchronous active-low reset.
- jdo in 38: JTAG data-out bus, sysclk-synchronous.
- take_action_ocimem_a in 1: 1-cycle strobe. Load JTAG address from jdo[17+ADDR_W:18]. If jdo[17]=1, also queue a read.
- take_no_action_ocimem_a in 1: 1-cycle strobe. Queue a read at the current JTAG address.
- take_action_ocimem_b in 1: 1-cycle strobe. Queue a write of jdo[34:3] at the current JTAG address.
- cpu_addr in ADDR_W: CPU word address.
- cpu_read in 1: CPU read request, held until accepted.
- cpu_write in 1: CPU write request, held until accepted.
- cpu_wdata in DATA_W: CPU write data.
- cpu_waitrequest out 1: low in the cycle the CPU request is accepted.
- cpu_rdata out DATA_W: CPU read data.
- cpu_rvalid out 1: CPU read data valid.
- ram_en out 1: RAM access this cycle.
- ram_we out 1: RAM write enable.
- ram_addr out ADDR_W: RAM address.
- ram_wdata out DATA_W: RAM write data.
- ram_rdata in DATA_W: RAM read data, 1-cycle synchronous read latency.
- MonDReg out 32: last JTAG read result.
- jtag_rd_done out 1: 1-cycle pulse when MonDReg is updated by a JTAG read.
- jtag_overrun out 1: sticky flag, JTAG request dropped.

Behaviour:
- Reset (async, reset_n=0) values:
  - all outputs 0, except cpu_waitrequest=1;
  - JTAG slot empty, jtag_addr=0, last_grant=CPU.
- JTAG slot (one deep):
  - A strobe loads it with the op {READ, WRITE} and the write data.
  - A strobe arriving while the slot is full is dropped and sets jtag_overrun. The flag clears only on reset.
  - take_action_ocimem_a without a read flag only updates jtag_addr.
  - An address load with the read flag while the slot is full: the address is still loaded, the read is dropped, and overrun is set.
  - More than one strobe in the same cycle: priority a > b > no_action_a. Lower-priority strobes are dropped and set overrun.
- Arbitration, evaluated every cycle:
  - Requesters: JTAG (slot full) and CPU (cpu_read|cpu_write).
  - Exactly one requester: it is granted.
  - Both requesting: the one not equal to last_grant is granted. last_grant updates on every grant.
  - cpu_read and cpu_write both high: treat as a write.
- Grant cycle N, combinational RAM drive:
  - ram_en=1, ram_addr, ram_we and ram_wdata are driven from the granted requester.
  - CPU grant: cpu_waitrequest=0 in cycle N only.
  - JTAG grant: the slot empties at the end of N, and jtag_addr increments modulo 2^ADDR_W (0xFF wraps to 0x00).
  - A slot write and grant in the same cycle is not possible: the slot is loaded at end of cycle, so it is granted from the next cycle on.
- Read return:
  - CPU: cpu_rvalid=1 in N+1, with cpu_rdata=ram_rdata combinationally.
  - JTAG: ram_rdata is registered into MonDReg at the end of N+1, and jtag_rd_done pulses in N+2.
  - Writes produce no response.
- Throughput: one RAM access per cycle. A CPU read and a JTAG read may be in flight back to back. A 1-bit return-tag pipeline steers each result.
- Reset mid-operation clears in-flight tags. No cpu_rvalid or jtag_rd_done follows reset.

Decomposition:
- Package nios2_ocimem_pkg:
  - ADDR_W/DATA_W defaults;
  - jdo field constants: JDO_ADDR_LSB=18, JDO_RDFLAG=17, JDO_WDATA_MSB=34, JDO_WDATA_LSB=3;
  - enum jtag_op_t {OP_NONE, OP_READ, OP_WRITE};
  - enum requester_t {REQ_CPU, REQ_JTAG}.
- One sub-module: nios2_ocimem_rr_arb2. It holds the 2-requester round-robin with the last_grant register, and outputs a one-hot grant.

Test Plan:
- Reset, then take_action_ocimem_a with jdo[25:18]=0x10 and jdo[17]=1, RAM[0x10]=0xDEADBEEF -> ram_addr=0x10 with ram_we=0 one cycle after the strobe; MonDReg=0xDEADBEEF; jtag_rd_done pulses; jtag_addr=0x11.
- Load addr 0xFF (no read flag), then take_action_ocimem_b with jdo[34:3]=0x12345678 -> RAM[0xFF] is written; jtag_addr wraps to 0x00. A following no_action read targets 0x00.
- CPU reads held continuously while JTAG issues a read -> grants alternate (JTAG first after reset). cpu_waitrequest is high only in the JTAG grant cycle; cpu_rvalid data and MonDReg each match their own addresses.
- take_no_action_ocimem_a twice while the CPU holds the RAM and JTAG lost the round-robin -> the second strobe is dropped and jtag_overrun=1 (sticky). Exactly one JTAG read completes.
- CPU write 0xA5A5A5A5 to 0x03, then CPU read of 0x03 back-to-back -> cpu_rvalid in the cycle after the read is accepted, with cpu_rdata=0xA5A5A5A5.
- reset_n asserted in the cycle after a JTAG read grant -> no jtag_rd_done; MonDReg=0; cpu_waitrequest=1.
